// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: state encoding,
// coin denominations in nickel units, and the greedy next-coin rule.
package vend_pkg;

  localparam int unsigned NICKEL_UNITS = 1;
  localparam int unsigned DIME_UNITS   = 2;
  localparam int unsigned COUNT_W      = 6;
  localparam int unsigned AMT_W        = 5;
  localparam int unsigned REFILL_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAN   = 3'd1,
    ST_DIME   = 3'd2,
    ST_NICKEL = 3'd3,
    ST_DONE   = 3'd4,
    ST_SHORT  = 3'd5
  } disp_state_e;

  // Dimes first while at least one dime's worth remains and a dime is in stock.
  function automatic disp_state_e greedy_next(input logic [AMT_W-1:0]   rem,
                                              input logic [COUNT_W-1:0] dimes);
    if (rem == '0)                                     return ST_DONE;
    else if (rem >= AMT_W'(DIME_UNITS) && dimes != '0) return ST_DIME;
    else                                               return ST_NICKEL;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Saturating coin counter: bulk add from a refill, single decrement per
// released coin. Never drops below zero.
module coin_inventory
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                add_en,
  input  logic [REFILL_W-1:0] add_amt,
  input  logic                dec,
  output logic [COUNT_W-1:0]  count
);

  logic [COUNT_W:0] sum;

  always_comb begin
    sum = {1'b0, count};
    if (add_en) sum = sum + (COUNT_W+1)'(add_amt);
    if (dec && sum != '0) sum = sum - (COUNT_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)            count <= '0;
    else if (sum[COUNT_W]) count <= '1;
    else                  count <= sum[COUNT_W-1:0];
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy dime/nickel change dispenser. PLAN checks feasibility against the
// whole inventory before any coin is released; coins then go out one per ack.
module change_dispenser
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [AMT_W-1:0]    req_amount,
  output logic                req_ready,
  output logic                disp_dime,
  output logic                disp_nickel,
  input  logic                disp_ack,
  output logic                done,
  output logic                short,
  input  logic                refill_valid,
  input  logic [REFILL_W-1:0] refill_dimes,
  input  logic [REFILL_W-1:0] refill_nickels,
  output logic [COUNT_W-1:0]  dime_count,
  output logic [COUNT_W-1:0]  nickel_count
);

  disp_state_e        state, state_d;
  logic [AMT_W-1:0]   rem, rem_d;
  logic               dime_dec, nick_dec, refill_en;
  logic [COUNT_W-1:0] half, d_use, need;
  logic               feasible;

  assign refill_en = (state == ST_IDLE) && refill_valid;

  coin_inventory u_dimes (
    .clk(clk), .reset(reset), .add_en(refill_en), .add_amt(refill_dimes),
    .dec(dime_dec), .count(dime_count)
  );

  coin_inventory u_nickels (
    .clk(clk), .reset(reset), .add_en(refill_en), .add_amt(refill_nickels),
    .dec(nick_dec), .count(nickel_count)
  );

  // d = min(dimes, rem/2); nickels must cover what the dimes cannot.
  always_comb begin
    half     = COUNT_W'(rem >> 1);
    d_use    = (dime_count < half) ? dime_count : half;
    need     = COUNT_W'(rem) - (d_use << 1);
    feasible = (nickel_count >= need);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      state <= state_d;
      rem   <= rem_d;
    end
  end

  always_comb begin
    state_d  = state;
    rem_d    = rem;
    dime_dec = 1'b0;
    nick_dec = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        rem_d   = req_amount;
        state_d = ST_PLAN;
      end
      ST_PLAN:   state_d = feasible ? greedy_next(rem, dime_count) : ST_SHORT;
      ST_DIME: if (disp_ack) begin
        dime_dec = 1'b1;
        rem_d    = rem - AMT_W'(DIME_UNITS);
        state_d  = greedy_next(rem - AMT_W'(DIME_UNITS), dime_count - COUNT_W'(1));
      end
      ST_NICKEL: if (disp_ack) begin
        nick_dec = 1'b1;
        rem_d    = rem - AMT_W'(NICKEL_UNITS);
        state_d  = greedy_next(rem - AMT_W'(NICKEL_UNITS), dime_count);
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_SHORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state == ST_IDLE);
  assign disp_dime   = (state == ST_DIME);
  assign disp_nickel = (state == ST_NICKEL);
  assign done        = (state == ST_DONE);
  assign short       = (state == ST_SHORT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a transaction table with hand-computed
// coin counts and inventories, plus hand sequences for the multi-cycle cases.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, req_valid, req_ready, disp_dime, disp_nickel, disp_ack;
  logic       done, short, refill_valid;
  logic [4:0] req_amount;
  logic [3:0] refill_dimes, refill_nickels;
  logic [5:0] dime_count, nickel_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .disp_dime(disp_dime), .disp_nickel(disp_nickel),
    .disp_ack(disp_ack), .done(done), .short(short),
    .refill_valid(refill_valid), .refill_dimes(refill_dimes),
    .refill_nickels(refill_nickels), .dime_count(dime_count),
    .nickel_count(nickel_count)
  );

  typedef struct {
    logic [3:0] rd, rn;
    logic [4:0] amt;
    int         ex_short, ex_nd, ex_nn, ex_dc, ex_nc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; disp_ack = 1'b0; refill_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic refill(input logic [3:0] rd, input logic [3:0] rn);
    refill_valid = 1'b1; refill_dimes = rd; refill_nickels = rn;
    step();
    refill_valid = 1'b0;
  endtask

  // Refill (if any), accept, then ack every coin immediately until done/short.
  task automatic run_txn(input logic [3:0] rd, input logic [3:0] rn, input logic [4:0] amt,
                         output int nd, output int nn, output int got_done,
                         output int got_short, output int bad_order);
    int cyc;
    nd = 0; nn = 0; got_done = 0; got_short = 0; bad_order = 0;
    if (rd != 0 || rn != 0) refill(rd, rn);
    req_valid = 1'b1; req_amount = amt;
    step();
    req_valid = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (disp_dime && disp_nickel) chk("both_coins", 1, 0);
      if (done)  begin got_done = 1;  break; end
      if (short) begin got_short = 1; break; end
      if (disp_dime || disp_nickel) begin
        if (disp_dime) begin nd++; if (nn > 0) bad_order = 1; end
        else nn++;
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        // Back-to-back: after an ack, either another coin or done, never a gap.
        chk("b2b", int'(disp_dime | disp_nickel | done), 1);
      end else step();
    end
    if (cyc >= 200) chk("txn_timeout", 0, 1);
    step();
  endtask

  vec_t vecs[10];

  initial begin
    int nd, nn, gd, gs, bo;
    vecs[0] = '{4'd3,  4'd5,  5'd5,  0, 2,  1, 1, 4};
    vecs[1] = '{4'd0,  4'd0,  5'd0,  0, 0,  0, 1, 4};
    vecs[2] = '{4'd0,  4'd0,  5'd6,  0, 1,  4, 0, 0};
    vecs[3] = '{4'd0,  4'd2,  5'd3,  1, 0,  0, 0, 2};
    vecs[4] = '{4'd1,  4'd1,  5'd4,  0, 1,  2, 0, 1};
    vecs[5] = '{4'd15, 4'd15, 5'd31, 0, 15, 1, 0, 15};
    vecs[6] = '{4'd2,  4'd0,  5'd1,  0, 0,  1, 2, 14};
    vecs[7] = '{4'd0,  4'd0,  5'd5,  0, 2,  1, 0, 13};
    vecs[8] = '{4'd0,  4'd0,  5'd5,  0, 0,  5, 0, 8};
    vecs[9] = '{4'd0,  4'd0,  5'd9,  1, 0,  0, 0, 8};

    req_amount = '0; refill_dimes = '0; refill_nickels = '0;
    do_reset();
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_outs", int'({disp_dime, disp_nickel, done, short}), 0);
    chk("rst_dc", int'(dime_count), 0);
    chk("rst_nc", int'(nickel_count), 0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].rd, vecs[i].rn, vecs[i].amt, nd, nn, gd, gs, bo);
      chk($sformatf("v%0d_short", i), gs, vecs[i].ex_short);
      chk($sformatf("v%0d_done", i), gd, 1 - vecs[i].ex_short);
      chk($sformatf("v%0d_ndimes", i), nd, vecs[i].ex_nd);
      chk($sformatf("v%0d_nnickels", i), nn, vecs[i].ex_nn);
      chk($sformatf("v%0d_order", i), bo, 0);
      chk($sformatf("v%0d_dc", i), int'(dime_count), vecs[i].ex_dc);
      chk($sformatf("v%0d_nc", i), int'(nickel_count), vecs[i].ex_nc);
      chk($sformatf("v%0d_ready", i), int'(req_ready), 1);
    end

    // Short: 0 dimes, 2 nickels, amount 3 -> short exactly 2 cycles after accept.
    do_reset();
    refill(4'd0, 4'd2);
    req_valid = 1'b1; req_amount = 5'd3;
    step();
    req_valid = 1'b0;
    chk("sh_c1", int'({disp_dime, disp_nickel, short}), 0);
    step();
    chk("sh_c2_short", int'(short), 1);
    chk("sh_c2_coins", int'({disp_dime, disp_nickel}), 0);
    step();
    chk("sh_c3_short", int'(short), 0);
    chk("sh_nc", int'(nickel_count), 2);

    // Ack withheld 5 cycles on the first dime; a new request meanwhile is ignored.
    do_reset();
    refill(4'd1, 4'd3);
    req_valid = 1'b1; req_amount = 5'd4;
    step();
    step();
    req_amount = 5'd7;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_dime%0d", k), int'(disp_dime), 1);
      if (k < 4) step();
    end
    req_valid = 1'b0;
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("hold_n1", int'(disp_nickel), 1);
    chk("hold_dc", int'(dime_count), 0);
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("hold_n2", int'(disp_nickel), 1);
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("hold_done", int'(done), 1);
    chk("hold_nc", int'(nickel_count), 1);
    step();
    chk("hold_idle", int'({req_ready, done}), 2);
    chk("hold_nc_final", int'(nickel_count), 1);

    // Saturation at 63, ack ignored in IDLE, refill ignored during NICKEL.
    do_reset();
    refill(4'd15, 4'd1);
    for (int k = 0; k < 3; k++) refill(4'd15, 4'd0);
    chk("sat_60", int'(dime_count), 60);
    refill(4'd15, 4'd0);
    chk("sat_63", int'(dime_count), 63);
    refill(4'd15, 4'd0);
    chk("sat_hold", int'(dime_count), 63);
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("idle_ack_nc", int'(nickel_count), 1);
    req_valid = 1'b1; req_amount = 5'd1;
    step();
    req_valid = 1'b0;
    step();
    chk("rf_nickel", int'(disp_nickel), 1);
    refill(4'd5, 4'd5);
    chk("rf_ign_dc", int'(dime_count), 63);
    chk("rf_ign_nc", int'(nickel_count), 1);
    chk("rf_still", int'(disp_nickel), 1);

    // Reset while the nickel waits for ack.
    reset = 1'b1;
    step();
    chk("mr_ready", int'(req_ready), 1);
    chk("mr_outs", int'({disp_dime, disp_nickel, done, short}), 0);
    chk("mr_counts", int'({dime_count, nickel_count}), 0);
    reset = 1'b0;
    step();
    chk("mr_after", int'({disp_dime, disp_nickel, done, short}), 0);

    // Amount 0: done exactly 2 cycles after accept.
    req_valid = 1'b1; req_amount = 5'd0;
    step();
    req_valid = 1'b0;
    chk("z_c1", int'(done), 0);
    step();
    chk("z_c2_done", int'(done), 1);
    chk("z_c2_coins", int'({disp_dime, disp_nickel}), 0);
    step();
    chk("z_c3", int'({done, req_ready}), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
